// File: rtl/frq_div_pkg.sv
// Shared defaults and helpers for the multi-channel frequency divider.
package frq_div_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int DEF_DIV_DEF = 10;

  // Channel-select width; a single channel still needs a one-bit select port.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frq_div_chan.sv
// One divider channel: free-running period counter with a shadowed divisor
// that is swapped in only at a period boundary (or at once while halted).
module frq_div_chan #(
  parameter int WIDTH   = 16,
  parameter int DEF_DIV = 10
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             ld_we_i,
  input  logic [WIDTH-1:0] ld_div_i,
  output logic             pend_o,
  output logic             tick_o,
  output logic             clk_out_o,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF     = WIDTH'(DEF_DIV);
  localparam logic             CLK_RST = (DEF_DIV >= 2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             tick_q, clk_out_q, clk_out_d;
  logic             wrap;

  assign wrap = en_i && (cnt_q == div_act_q - ONE);

  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    if (ld_we_i) begin
      div_pend_d = ld_div_i;
      pend_d     = 1'b1;
    end
    if (wrap) begin
      cnt_d = '0;
      // A load arriving on the wrap cycle bypasses the shadow register.
      if (ld_we_i) begin
        div_act_d = ld_div_i;
        pend_d    = 1'b0;
      end else if (pend_q) begin
        div_act_d = div_pend_q;
        pend_d    = 1'b0;
      end
    end else if (en_i) begin
      cnt_d = cnt_q + ONE;
    end else if (pend_q) begin
      div_act_d = div_pend_q;
      pend_d    = 1'b0;
      cnt_d     = '0;
    end
    clk_out_d = (cnt_d < (div_act_d >> 1));
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      div_act_q  <= DEF;
      div_pend_q <= DEF;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      clk_out_q  <= CLK_RST;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      tick_q     <= wrap;
      clk_out_q  <= clk_out_d;
    end
  end

  assign pend_o    = pend_q;
  assign tick_o    = tick_q;
  assign clk_out_o = clk_out_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/frq_div_multi.sv
// NUM_CH independent programmable dividers sharing one master clock and a
// single valid/ready divisor-load port.
module frq_div_multi
  import frq_div_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NUM_CH  = 4,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                      mclk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      ld_valid,
  input  logic [ch_w(NUM_CH)-1:0]   ld_ch,
  input  logic [WIDTH-1:0]          ld_div,
  output logic                      ld_ready,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH*WIDTH-1:0]   count
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] ld_we;
  logic [WIDTH-1:0]  div_in;

  assign div_in = (ld_div == '0) ? WIDTH'(1) : ld_div;

  // Out-of-range channel numbers stay ready so the request is drained and dropped.
  always_comb begin
    ld_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ld_ch == CH_W'(i)) ld_ready = !pend[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ld_we[g] = ld_valid && ld_ready && (ld_ch == CH_W'(g));

    frq_div_chan #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .mclk      (mclk),
      .reset     (reset),
      .en_i      (en),
      .ld_we_i   (ld_we[g]),
      .ld_div_i  (div_in),
      .pend_o    (pend[g]),
      .tick_o    (tick[g]),
      .clk_out_o (clk_out[g]),
      .cnt_o     (count[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_frq_div_multi.sv
// Self-checking bench for frq_div_multi (WIDTH=16, NUM_CH=4, DEF_DIV=10).
module tb_frq_div_multi;

  localparam int W = 16;
  localparam int N = 4;

  logic           mclk = 1'b0;
  logic           reset;
  logic           en;
  logic           ld_valid;
  logic [1:0]     ld_ch;
  logic [W-1:0]   ld_div;
  logic           ld_ready;
  logic [N-1:0]   tick;
  logic [N-1:0]   clk_out;
  logic [N*W-1:0] count;

  int checks = 0;
  int errors = 0;

  // Reference state: position in period, active divisor, queued divisor.
  int           m_cnt[N];
  int           m_div[N];
  int           m_pdiv[N];
  bit           m_pend[N];
  logic [N-1:0] m_tick;

  typedef struct {
    logic       en;
    logic [W-1:0] cnt;
    logic       tck;
    logic       clk;
  } vec_t;
  vec_t tbl[13];

  always #5 mclk = ~mclk;

  frq_div_multi #(.WIDTH(W), .NUM_CH(N), .DEF_DIV(10)) dut (
    .mclk     (mclk),
    .reset    (reset),
    .en       (en),
    .ld_valid (ld_valid),
    .ld_ch    (ld_ch),
    .ld_div   (ld_div),
    .ld_ready (ld_ready),
    .tick     (tick),
    .clk_out  (clk_out),
    .count    (count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_clk();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = (m_cnt[c] < m_div[c] / 2);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_cnt[c]  = 0;
      m_div[c]  = 10;
      m_pdiv[c] = 10;
      m_pend[c] = 1'b0;
    end
    m_tick = '0;
  endtask

  task automatic model_edge();
    int nd;
    nd = (ld_div == 0) ? 1 : int'(ld_div);
    for (int c = 0; c < N; c++) begin
      bit last;
      bit xfer;
      last = en && (m_cnt[c] == m_div[c] - 1);
      xfer = ld_valid && (int'(ld_ch) == c) && !m_pend[c];
      m_tick[c] = last;
      if (last) begin
        m_cnt[c] = 0;
        if (xfer) m_div[c] = nd;
        else if (m_pend[c]) begin
          m_div[c]  = m_pdiv[c];
          m_pend[c] = 1'b0;
        end
      end else if (en) begin
        m_cnt[c] = m_cnt[c] + 1;
        if (xfer) begin
          m_pdiv[c] = nd;
          m_pend[c] = 1'b1;
        end
      end else if (m_pend[c]) begin
        m_div[c]  = m_pdiv[c];
        m_pend[c] = 1'b0;
        m_cnt[c]  = 0;
      end else if (xfer) begin
        m_pdiv[c] = nd;
        m_pend[c] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < N; c++)
      check($sformatf("count[%0d]", c), 64'(count[c*W +: W]), 64'(m_cnt[c]));
    check("tick", 64'(tick), 64'(m_tick));
    check("clk_out", 64'(clk_out), 64'(m_clk()));
    check("ld_ready", 64'(ld_ready), 64'(!m_pend[ld_ch]));
  endtask

  task automatic step();
    @(posedge mclk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_cnt(input int c, input int v);
    int k;
    k = 0;
    while ((int'(count[c*W +: W]) != v) && (k < 64)) begin
      step();
      k++;
    end
    if (k >= 64) check($sformatf("wait_cnt%0d", c), 64'(count[c*W +: W]), 64'(v));
  endtask

  task automatic async_reset();
    @(negedge mclk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2;
    reset = 1'b0;
  endtask

  task automatic load(input int c, input int d);
    ld_valid = 1'b1;
    ld_ch    = 2'(c);
    ld_div   = W'(d);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'd1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 16'd2, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 16'd3, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 16'd4, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 16'd5, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'd6, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 16'd7, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 16'd8, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 16'd9, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 16'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 16'd1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 16'd1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 16'd1, 1'b0, 1'b1};

    reset = 1'b1; en = 1'b0; ld_valid = 1'b0; ld_ch = '0; ld_div = '0;
    repeat (2) @(posedge mclk);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_count", 64'(count), 64'(0));
    check("rst_tick", 64'(tick), 64'(0));
    check("rst_clk_out", 64'(clk_out), 64'(4'hF));
    check("rst_ld_ready", 64'(ld_ready), 64'(1));

    // Default divide-by-10 from reset, then hold with en low.
    for (int i = 0; i < 13; i++) begin
      en = tbl[i].en;
      step();
      for (int c = 0; c < N; c++)
        check($sformatf("tbl%0d_cnt%0d", i, c), 64'(count[c*W +: W]), 64'(tbl[i].cnt));
      check($sformatf("tbl%0d_tick", i), 64'(tick), 64'({N{tbl[i].tck}}));
      check($sformatf("tbl%0d_clk", i), 64'(clk_out), 64'({N{tbl[i].clk}}));
    end

    // Async reset mid-period drops a pending load.
    en = 1'b1;
    wait_cnt(0, 5);
    load(1, 3);
    step();
    ld_valid = 1'b0;
    check("s6_pend_rdy", 64'(ld_ready), 64'(0));
    wait_cnt(0, 7);
    async_reset();
    check("s6_count", 64'(count), 64'(0));
    check("s6_tick", 64'(tick), 64'(0));
    check("s6_clk_out", 64'(clk_out), 64'(4'hF));
    check("s6_rdy", 64'(ld_ready), 64'(1));
    repeat (12) step();

    // ch1 <- 3 accepted at cnt=4, applied at wrap.
    wait_cnt(1, 4);
    load(1, 3);
    check("s2_rdy_pre", 64'(ld_ready), 64'(1));
    step();
    ld_valid = 1'b0;
    check("s2_rdy_low", 64'(ld_ready), 64'(0));
    wait_cnt(1, 9);
    step();
    check("s2_tick1", 64'(tick[1]), 64'(1));
    check("s2_rdy_back", 64'(ld_ready), 64'(1));
    repeat (9) step();

    // ch2 <- 4 on its wrap cycle takes effect immediately.
    wait_cnt(2, 9);
    load(2, 4);
    check("s3_rdy_pre", 64'(ld_ready), 64'(1));
    step();
    ld_valid = 1'b0;
    check("s3_rdy_post", 64'(ld_ready), 64'(1));
    check("s3_cnt", 64'(count[2*W +: W]), 64'(0));
    repeat (12) step();

    // ch0 <- 0 (stored as 1); second load held off while pending.
    wait_cnt(0, 2);
    load(0, 0);
    check("s4_rdy_pre", 64'(ld_ready), 64'(1));
    step();
    ld_div = W'(7);
    check("s4_holdoff", 64'(ld_ready), 64'(0));
    repeat (3) step();
    ld_valid = 1'b0;
    repeat (12) step();
    check("s4_tick0", 64'(tick[0]), 64'(1));
    check("s4_clk0", 64'(clk_out[0]), 64'(0));
    step();
    check("s4_tick0b", 64'(tick[0]), 64'(1));

    // en drops with a pending divisor on ch3: applied next edge, cnt forced to 0.
    wait_cnt(3, 3);
    load(3, 5);
    step();
    ld_valid = 1'b0;
    wait_cnt(3, 6);
    en = 1'b0;
    step();
    check("s5_cnt", 64'(count[3*W +: W]), 64'(0));
    check("s5_tick", 64'(tick), 64'(0));
    step();
    check("s5_tick_b", 64'(tick), 64'(0));
    en = 1'b1;
    repeat (12) step();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      ld_valid = ($urandom_range(0, 4) == 0);
      ld_ch    = 2'($urandom_range(0, 3));
      ld_div   = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 8));
      if ($urandom_range(0, 999) == 0) async_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frq_div_multi.md
# frq_div_multi

Multi-channel programmable frequency divider, the parametrised successor of the fixed single-channel divider used in the BCD counter / segment-display path. From one master clock it produces NUM_CH independent divided outputs, each with a one-cycle enable strobe (`tick`) and a near-50 % square wave (`clk_out`). Each channel's divide ratio can be reloaded at runtime through a valid/ready load port, with the new ratio taking effect only at that channel's period boundary. It feeds the counter, scan and blink timing of the display logic.

## Interface
- WIDTH, 16, width of each channel's divisor and counter
- NUM_CH, 4, number of independent channels (≥1)
- DEF_DIV, 10, divisor loaded into every channel at reset (1 ≤ DEF_DIV < 2^WIDTH)
- mclk  in  1  master clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  global count enable; counters hold while low
- ld_valid  in  1  load request
- ld_ch  in  max(1,$clog2(NUM_CH))  target channel of load
- ld_div  in  WIDTH  new divisor; 0 is stored as 1
- ld_ready  out  1  load can be accepted for channel ld_ch (combinational from ld_ch and pending state)
- tick  out  NUM_CH  per-channel one-cycle strobe at period wrap
- clk_out  out  NUM_CH  per-channel divided square wave
- count  out  NUM_CH*WIDTH  per-channel counter, channel i at bits [i*WIDTH +: WIDTH]

## Operation
- Per channel: registers cnt, div_act, div_pend, pend (flag).
- Counting: when en=1, cnt advances 0,1,…,div_act−1, then wraps to 0. When en=0, cnt holds.
- tick(t+1) = en(t) & (cnt(t) == div_act(t)−1); tick is therefore high in the cycle in which cnt shows 0 after a wrap.
- clk_out is registered: clk_out = (cnt_next < div_act_next>>1). This gives div>>1 cycles high and the remainder low. For div=1, tick is continuously high while en=1 and clk_out is constantly 0.
- Load handshake: a transfer occurs when ld_valid & ld_ready. ld_ready = !pend[ld_ch]. An ld_ch ≥ NUM_CH gives ld_ready=1, and the load is discarded.
- On transfer: div_pend[ld_ch] ← (ld_div==0 ? 1 : ld_div) and pend ← 1.
- Apply pending: at the next wrap (en=1 and cnt == div_act−1), div_act ← div_pend, pend ← 0, cnt ← 0.
- If en=0 and pend=1, the pending value is applied on the next edge and cnt is forced to 0.
- Simultaneous transfer and wrap on the same channel: the new divisor applies at that wrap. The next period uses the new value, and pend stays 0.
- Reset values: cnt=0, div_act=DEF_DIV, pend=0, tick=0, clk_out = (DEF_DIV ≥ 2), count=0.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a mclk edge, and any pending load is dropped.

## Timing
- Period per channel = div_act mclk cycles; first tick comes div_act cycles after en rises from reset.
- Load latency: from acceptance to effect is at most one full period, plus one cycle if en=0.
- ld_ready may fall the cycle after a transfer and rises the cycle after the apply.
- No combinational path from ld_* to tick, clk_out or count.

## Structure
- Package frq_div_pkg: the DEF_DIV default, WIDTH default, and a helper function for ld_ch width (clog2 with minimum 1).
- Sub-module frq_div_chan: one channel holding the cnt/div_act/div_pend/pend registers, tick and clk_out, instantiated NUM_CH times in a generate loop.
- The top level decodes ld_ch, muxes ld_ready and concatenates count.

## Test plan
All scenarios use WIDTH=16, NUM_CH=4, DEF_DIV=10.
- Reset, then en=1: each channel ticks every 10 cycles, with the first tick 10 cycles after en. clk_out runs 5 high / 5 low, and count runs 0..9.
- Load ch1 with div 3 at cnt=4: transfer accepted and ld_ready(ch1)=0 until the wrap at cnt=9. Afterwards ch1 ticks every 3 cycles with clk_out 1 high / 2 low; the other channels are unaffected.
- Load ch2 with div 4 in its cnt=9 cycle: the following period is already 4 cycles, and ld_ready never drops.
- Load ch0 with ld_div=0: after the wrap, tick[0] stays continuously high and clk_out[0]=0. A second load while pend=1 is held off by ld_ready=0.
- en=0 at cnt=6 with a pending div 5: on the next edge cnt=0 and div_act=5 and ticks stay 0. When en returns to 1, the period is 5.
- Assert reset between mclk edges at cnt=7: count, tick and pend clear immediately, and clk_out returns to 1.
